// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between
// the instruction-fetch port and the load/store data port (req/ack handshakes).
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ADDRW   = 14,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [ADDRW-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ADDRW-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant_d;       // current transaction belongs to the data port
    logic             last_grant_d;  // winner of the most recent conflict
    logic             lat_we;
    logic [3:0]       cnt;

    logic             pick_d;
    logic             grant_start;
    logic             capture;
    logic             mem_en_nxt;
    logic             mem_we_nxt;
    logic [ADDRW-1:0] mem_addr_nxt;
    logic [WIDTH-1:0] mem_wdata_nxt;
    logic             i_ack_nxt;
    logic             d_ack_nxt;

    // On a conflict the port that lost the previous conflict wins this one.
    assign pick_d      = d_req && (!i_req || !last_grant_d);
    assign grant_start = (state == S_IDLE) && (i_req || d_req);
    assign capture     = (state == S_WAIT) && (cnt == '0);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_req || d_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        if (grant_start) begin
            mem_en_nxt   = 1'b1;
            mem_we_nxt   = pick_d && d_we;
            mem_addr_nxt = pick_d ? d_addr : i_addr;
            if (pick_d && d_we) mem_wdata_nxt = d_wdata;
        end
        i_ack_nxt = (state_nxt == S_RESP) && !grant_d;
        d_ack_nxt = (state_nxt == S_RESP) && grant_d;
    end

    // The memory strobe is loaded on the edge that enters ISSUE, so it is high exactly there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            lat_we       <= 1'b0;
            cnt          <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            if (grant_start) begin
                grant_d <= pick_d;
                lat_we  <= pick_d && d_we;
                if (i_req && d_req) last_grant_d <= pick_d;
            end
            if (state == S_ISSUE)                 cnt <= 4'(LATENCY - 1);
            else if (state == S_WAIT && cnt != '0) cnt <= cnt - 4'd1;
            if (capture) begin
                if (grant_d) d_rdata <= mem_rdata;
                else         i_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, and random traffic against a transaction-level scheduling model.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam logic [13:0] A0  = 14'h0;
    localparam logic [13:0] A10 = 14'h10;
    localparam logic [13:0] A20 = 14'h20;
    localparam logic [31:0] W0  = 32'h0;
    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] ST  = 32'h12345678;
    localparam logic [31:0] BAD = 32'hBAD0BAD0;

    logic        clk, rst;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [13:0] i_addr, d_addr, mem_addr;
    logic [31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy;

    logic        l1_i_req, l1_i_ack, l1_d_req, l1_d_we, l1_d_ack;
    logic [13:0] l1_i_addr, l1_d_addr, l1_mem_addr;
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_d_wdata, l1_mem_wdata, l1_mem_rdata;
    logic        l1_mem_en, l1_mem_we, l1_busy;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.WIDTH(32), .ADDRW(14), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WIDTH(32), .ADDRW(14), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata), .i_ack(l1_i_ack),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [13:0] a);
        if (a == 14'h10) return DB;
        if (a == 14'h05) return 32'h0000ABCD;
        return {2'b10, a, 2'b01, ~a};
    endfunction

    // Memory macro for the LATENCY=2 instance; rdata is poisoned outside its valid cycle.
    logic [31:0] mem [0:16383];
    logic [31:0] p0_d, p1_d;
    logic        p0_v, p1_v;
    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = init_word(14'(a));
        p0_v = 1'b0; p1_v = 1'b0; p0_d = W0; p1_d = W0;
        forever begin
            @(posedge clk);
            p0_d <= mem[mem_addr];
            p0_v <= mem_en && !mem_we;
            p1_d <= p0_d;
            p1_v <= p0_v;
            if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        end
    end
    assign mem_rdata = p1_v ? p1_d : BAD;

    logic [31:0] q_d;
    logic        q_v;
    initial begin
        q_v = 1'b0; q_d = W0;
        forever begin
            @(posedge clk);
            q_d <= init_word(l1_mem_addr);
            q_v <= l1_mem_en && !l1_mem_we;
        end
    end
    assign l1_mem_rdata = q_v ? q_d : BAD;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (n_bad=%0d)", n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_req = 1'b0; i_addr = A0; d_req = 1'b0; d_we = 1'b0; d_addr = A0; d_wdata = W0;
        l1_i_req = 1'b0; l1_i_addr = A0; l1_d_req = 1'b0; l1_d_we = 1'b0;
        l1_d_addr = A0; l1_d_wdata = W0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic        i_req;
        logic [13:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [13:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_en;
        logic        e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iack;
        logic        e_dack;
        logic        e_busy;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
    } vec_t;

    vec_t tbl [15];

    task automatic run_table();
        tbl[0]  = '{1'b1, A10, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b0, W0, W0};
        tbl[1]  = '{1'b1, A10, 1'b0, 1'b0, A0,  W0, 1'b1, 1'b0, A10, W0, 1'b0, 1'b0, 1'b1, W0, W0};
        tbl[2]  = '{1'b1, A10, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b1, W0, W0};
        tbl[3]  = '{1'b1, A10, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b1, W0, W0};
        tbl[4]  = '{1'b1, A10, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b1, 1'b0, 1'b1, DB, W0};
        tbl[5]  = '{1'b0, A0,  1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b0, DB, W0};
        tbl[6]  = '{1'b0, A0,  1'b1, 1'b1, A20, ST, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b0, DB, W0};
        tbl[7]  = '{1'b0, A0,  1'b1, 1'b1, A20, ST, 1'b1, 1'b1, A20, ST, 1'b0, 1'b0, 1'b1, DB, W0};
        tbl[8]  = '{1'b0, A0,  1'b1, 1'b1, A20, ST, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b1, 1'b1, DB, W0};
        tbl[9]  = '{1'b0, A0,  1'b1, 1'b0, A20, W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b0, DB, W0};
        tbl[10] = '{1'b0, A0,  1'b1, 1'b0, A20, W0, 1'b1, 1'b0, A20, W0, 1'b0, 1'b0, 1'b1, DB, W0};
        tbl[11] = '{1'b0, A0,  1'b1, 1'b0, A20, W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b1, DB, W0};
        tbl[12] = '{1'b0, A0,  1'b1, 1'b0, A20, W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b1, DB, W0};
        tbl[13] = '{1'b0, A0,  1'b1, 1'b0, A20, W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b1, 1'b1, DB, ST};
        tbl[14] = '{1'b0, A0,  1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, A0,  W0, 1'b0, 1'b0, 1'b0, DB, ST};
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            i_req = tbl[i].i_req; i_addr = tbl[i].i_addr;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we;
            d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            @(negedge clk);
            check($sformatf("tbl[%0d] mem_en", i), mem_en, tbl[i].e_en);
            check($sformatf("tbl[%0d] mem_we", i), mem_we, tbl[i].e_we);
            if (tbl[i].e_en) check($sformatf("tbl[%0d] mem_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_en && tbl[i].e_we)
                check($sformatf("tbl[%0d] mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            check($sformatf("tbl[%0d] i_ack", i), i_ack, tbl[i].e_iack);
            check($sformatf("tbl[%0d] d_ack", i), d_ack, tbl[i].e_dack);
            check($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl[%0d] i_rdata", i), i_rdata, tbl[i].e_ir);
            check($sformatf("tbl[%0d] d_rdata", i), d_rdata, tbl[i].e_dr);
        end
    endtask

    // Both ports raise at T straight after reset: data wins, fetch follows from IDLE at T+5.
    task automatic run_conflict();
        bit i_seen = 0, d_seen = 0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            i_req = !i_seen; i_addr = A10;
            d_req = !d_seen; d_we = 1'b0; d_addr = 14'h05; d_wdata = W0;
            @(negedge clk);
            check($sformatf("conf k=%0d mem_en", k), mem_en, (k == 1 || k == 6));
            if (k == 1) check("conf data addr", mem_addr, 14'h05);
            if (k == 6) check("conf fetch addr", mem_addr, A10);
            check($sformatf("conf k=%0d d_ack", k), d_ack, (k == 4));
            check($sformatf("conf k=%0d i_ack", k), i_ack, (k == 9));
            check($sformatf("conf k=%0d d_rdata", k), d_rdata, (k >= 4) ? 32'h0000ABCD : W0);
            check($sformatf("conf k=%0d i_rdata", k), i_rdata, (k >= 9) ? DB : W0);
            if (d_ack) d_seen = 1;
            if (i_ack) i_seen = 1;
        end
    endtask

    // Both ports request continuously; grants must alternate starting with data.
    task automatic run_alternate();
        bit order [$];
        int k = 0;
        i_addr = A10; d_we = 1'b1; d_addr = 14'h30; d_wdata = 32'hA5A55A5A;
        while (order.size() < 6 && k < 200) begin
            @(posedge clk); #1;
            i_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            check("alt both acks", {i_ack, d_ack} == 2'b11, 1'b0);
            if (d_ack) order.push_back(1'b1);
            if (i_ack) order.push_back(1'b0);
            k++;
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        check("alt ack count", order.size(), 6);
        for (int j = 0; j < order.size(); j++)
            check($sformatf("alt grant %0d is data", j), order[j], (j % 2 == 0));
    endtask

    // Asynchronous reset during WAIT of a fetch, then a fresh fetch.
    task automatic run_async_reset();
        int ack_k = -1;
        repeat (3) @(posedge clk);
        #1 i_req = 1'b1; i_addr = A10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset busy", busy, 1'b1);
        check("pre-reset i_rdata", i_rdata, DB);
        #1 rst = 1'b0; i_req = 1'b0;
        #1;
        check("async rst busy", busy, 1'b0);
        check("async rst i_rdata", i_rdata, W0);
        check("async rst outs", {i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, d_rdata}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post rst no ack", {i_ack, d_ack}, 2'b00);
        end
        for (int k = 0; k < 20 && ack_k < 0; k++) begin
            @(posedge clk); #1;
            i_req = 1'b1; i_addr = A10;
            @(negedge clk);
            if (i_ack) begin
                ack_k = k;
                check("refetch i_rdata", i_rdata, DB);
            end
        end
        @(posedge clk); #1 i_req = 1'b0;
        check("refetch latency", ack_k, 4);
    endtask

    task automatic run_latency1();
        bit seen = 0;
        int ack_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            l1_d_req = !seen; l1_d_we = 1'b0; l1_d_addr = 14'h05;
            @(negedge clk);
            check($sformatf("lat1 k=%0d mem_en", k), l1_mem_en, (k == 1));
            if (k == 1) check("lat1 mem_addr", l1_mem_addr, 14'h05);
            if (l1_d_ack && !seen) begin
                ack_k = k;
                check("lat1 d_rdata", l1_d_rdata, 32'h0000ABCD);
            end
            if (l1_d_ack) seen = 1;
        end
        check("lat1 ack cycle", ack_k, 3);
    endtask

    // Transaction-level model: an IDLE cycle with requests starts a transaction whose
    // strobe and ack cycles follow from fixed arithmetic; memory is a plain array.
    logic [31:0] ref_mem [0:16383];

    task automatic run_random(input int ncyc);
        bit ip = 0, dp = 0, act = 0, last_conf_d = 0, m_d = 0, m_we = 0;
        int t_start = 0, t_issue = -1, t_ack = -1, free_at = 0;
        logic [13:0] m_addr = A0;
        logic [31:0] m_wdata = W0, m_rdata = W0, exp_ir = W0, exp_dr = W0;
        for (int a = 0; a < 16384; a++) ref_mem[a] = init_word(14'(a));
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (!ip && ($urandom % 3 == 0)) begin
                ip = 1; i_addr = 14'h100 + 14'($urandom % 16);
            end
            if (!dp && ($urandom % 3 == 0)) begin
                dp = 1; d_we = 1'($urandom); d_addr = 14'h100 + 14'($urandom % 16);
                d_wdata = $urandom;
            end
            i_req = ip; d_req = dp;
            @(negedge clk);
            if (act && c == t_ack && !m_we) begin
                if (m_d) exp_dr = m_rdata;
                else     exp_ir = m_rdata;
            end
            check("rnd i_ack", i_ack, act && c == t_ack && !m_d);
            check("rnd d_ack", d_ack, act && c == t_ack && m_d);
            check("rnd mem_en", mem_en, act && c == t_issue);
            check("rnd mem_we", mem_we, act && c == t_issue && m_we);
            check("rnd busy", busy, act && c > t_start && c <= t_ack);
            if (act && c == t_issue) begin
                check("rnd mem_addr", mem_addr, m_addr);
                if (m_we) check("rnd mem_wdata", mem_wdata, m_wdata);
            end
            check("rnd i_rdata", i_rdata, exp_ir);
            check("rnd d_rdata", d_rdata, exp_dr);
            if (i_ack) ip = 0;
            if (d_ack) dp = 0;
            if (act && c == t_ack) begin
                act = 0; free_at = c + 1;
            end
            if (!act && c >= free_at && (i_req || d_req)) begin
                if (i_req && d_req) begin
                    m_d = !last_conf_d; last_conf_d = m_d;
                end else begin
                    m_d = d_req;
                end
                m_we    = m_d && d_we;
                m_addr  = m_d ? d_addr : i_addr;
                m_wdata = d_wdata;
                act = 1; t_start = c; t_issue = c + 1;
                t_ack   = m_we ? c + 2 : c + 2 + LAT;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdata = ref_mem[m_addr];
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset acks", {i_ack, d_ack}, 2'b00);
        check("reset mem_en/we", {mem_en, mem_we}, 2'b00);
        check("reset mem_addr", mem_addr, A0);
        check("reset mem_wdata", mem_wdata, W0);
        check("reset i_rdata", i_rdata, W0);
        check("reset d_rdata", d_rdata, W0);
        @(posedge clk); #1 rst = 1'b1;

        run_table();
        do_reset();
        run_conflict();
        do_reset();
        run_alternate();
        run_async_reset();
        run_latency1();
        do_reset();
        run_random(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
